// File: rtl/imem_loader_pkg.sv
// Shared definitions for the IMEM byte-stream loader.
// The checksum stage is built only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  // Default frame start marker.
  localparam logic [7:0] LOADER_SYNC_DEFAULT = 8'hA5;

  // Loader FSM state encoding.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StChk   = 3'd4,
    StDone  = 3'd5
  } loader_state_e;

  // State entered once the last payload byte (or an empty length) has been taken.
  function automatic loader_state_e payload_end_state();
`ifdef LOADER_CHECKSUM_EN
    return StChk;
`else
    return StDone;
`endif
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// Running XOR of payload bytes, used as the frame checksum.
// Instantiated by imem_loader only when LOADER_CHECKSUM_EN is defined.
module loader_xor_acc (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q, acc_d;

  // Clear wins over accumulate; otherwise fold in each enabled byte.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = 8'h00;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses sync/length/payload[/checksum] frames from a
// valid/ready byte stream and writes the payload into IMEM one byte per cycle.
// The core is held in reset until a frame completes cleanly.
// Optional checksum byte after the payload: define LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_NBYTE = 4096,
  parameter int unsigned ADDR_W    = $clog2(MEM_NBYTE),
  parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam int unsigned MaxWords = MEM_NBYTE / 4;

  loader_state_e     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W-1:0] ctr_q, ctr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              err_q, err_d;

  logic              accept;
  logic              sync_hit;
  logic [15:0]       len_word;
  logic [17:0]       len_nbyte;
  logic              len_too_long;

  // Only DONE stalls the stream.
  assign s_ready  = (state_q != StDone);
  assign accept   = s_valid & s_ready;
  assign sync_hit = accept && (state_q == StIdle) && (s_data == SYNC_BYTE);

  // Word count completes when the high byte arrives.
  assign len_word     = {s_data, len_lo_q};
  assign len_nbyte    = {len_word, 2'b00};
  assign len_too_long = (32'(len_word) > MaxWords);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_en;

  assign chk_en = accept && (state_q == StData);

  loader_xor_acc u_xor_acc (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (sync_hit),
    .en_i    (chk_en),
    .data_i  (s_data),
    .acc_o   (chk_acc)
  );
`endif

  // Next-state, counters and write-port register inputs.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    ctr_d       = ctr_q;
    last_d      = last_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (sync_hit) begin
          state_d     = StLenLo;
          err_d       = 1'b0;
          cpu_rst_n_d = 1'b0;
          ctr_d       = '0;
        end
      end

      StLenLo: begin
        if (accept) begin
          len_lo_d = s_data;
          state_d  = StLenHi;
        end
      end

      StLenHi: begin
        if (accept) begin
          if (len_too_long) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (len_word == 16'd0) begin
            state_d = payload_end_state();
          end else begin
            // Index of the final payload byte; fits because the length was bounded.
            last_d  = ADDR_W'(len_nbyte - 18'd1);
            state_d = StData;
          end
        end
      end

      StData: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = ctr_q;
          wdata_d = s_data;
          ctr_d   = ctr_q + ADDR_W'(1);
          if (ctr_q == last_q) begin
            state_d = payload_end_state();
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          if (s_data == chk_acc) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif

      StDone: begin
        // Core leaves reset the cycle after the done pulse.
        cpu_rst_n_d = 1'b1;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_lo_q    <= 8'h00;
      ctr_q       <= '0;
      last_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 8'h00;
      cpu_rst_n_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      ctr_q       <= ctr_d;
      last_q      <= last_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign err       = err_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized frames against a payload-image model.
module tb_imem_loader;

  localparam int unsigned MEM_NBYTE = 4096;
  localparam int unsigned ADDR_W    = 12;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [7:0]        payload_q[$];
  logic [ADDR_W-1:0] waddr_log[$];
  logic [7:0]        wdata_log[$];

  imem_loader #(
    .MEM_NBYTE (MEM_NBYTE),
    .ADDR_W    (ADDR_W),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every IMEM write strobe.
  always @(negedge clk) begin
    if (mem_we) begin
      waddr_log.push_back(mem_waddr);
      wdata_log.push_back(mem_wdata);
    end
  end

  task automatic clear_log();
    waddr_log.delete();
    wdata_log.delete();
  endtask

  task automatic fill_payload(input int nbytes);
    payload_q.delete();
    for (int i = 0; i < nbytes; i++) payload_q.push_back(8'($urandom));
  endtask

  // Offer one byte after a random idle gap; returns just after it is accepted.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int guard;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    guard   = 0;
    while (!s_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 8) begin
      errors++;
      $display("FAIL ready_timeout: s_ready stayed 0 for %0d cycles, required 1", guard);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Full frame from payload_q with the given word count.
  task automatic send_frame(input int words, input int maxgap);
    logic [15:0] len16;
    logic [7:0]  x;
    len16 = words[15:0];
    x     = 8'h00;
    send_byte(8'hA5, maxgap);
    send_byte(len16[7:0], maxgap);
    send_byte(len16[15:8], maxgap);
    foreach (payload_q[i]) begin
      send_byte(payload_q[i], maxgap);
      x ^= payload_q[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, maxgap);
`endif
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks += 7;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    if (mem_waddr !== '0) begin errors++; $display("FAIL rst_waddr: got %h want 0", mem_waddr); end
    if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_rst_n: got %b want 0", cpu_rst_n); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic exp_we_last;
`ifdef LOADER_CHECKSUM_EN
    exp_we_last = 1'b0;
`else
    exp_we_last = 1'b1;
`endif
    payload_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    clear_log();
    send_frame(2, 0);
    @(negedge clk);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL basic_cpu_rst_during_done: got %b want 0", cpu_rst_n); end
    if (mem_we !== exp_we_last) begin errors++; $display("FAIL basic_last_we: got %b want %b", mem_we, exp_we_last); end
    @(negedge clk);
    checks += 2;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL basic_cpu_rst_after: got %b want 1", cpu_rst_n); end
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    @(negedge clk);
    checks++;
    if (waddr_log.size() !== 8) begin
      errors++; $display("FAIL basic_count: got %0d writes want 8", waddr_log.size());
    end else begin
      for (int w = 0; w < 2; w++) begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (waddr_log[4*w+k] !== ADDR_W'(4*w+k) || wdata_log[4*w+k] !== payload_q[4*w+k]) begin
            errors++;
            $display("FAIL basic_write%0d: got %h/%h want %h/%h", 4*w+k, waddr_log[4*w+k],
                     wdata_log[4*w+k], 4*w+k, payload_q[4*w+k]);
          end
        end
      end
    end
  endtask

  task automatic test_garbage_prefix();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    @(negedge clk);
    checks += 2;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL idle_cpu_rst: got %b want 1", cpu_rst_n); end
    if (waddr_log.size() !== 0) begin errors++; $display("FAIL idle_writes: got %0d want 0", waddr_log.size()); end
    fill_payload(4);
    send_frame(1, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL garbage_done: got %b want 1", done); end
    repeat (2) @(negedge clk);
    checks++;
    if (waddr_log.size() !== 4) begin
      errors++; $display("FAIL garbage_count: got %0d writes want 4", waddr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (waddr_log[i] !== ADDR_W'(i) || wdata_log[i] !== payload_q[i]) begin
          errors++;
          $display("FAIL garbage_write%0d: got %h/%h want %h/%h", i, waddr_log[i], wdata_log[i],
                   i, payload_q[i]);
        end
      end
    end
  endtask

  task automatic test_len_err();
    clear_log();
    send_byte(8'hA5, 0);
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL sync_cpu_rst: got %b want 0", cpu_rst_n); end
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL len_err: got %b want 1", err); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL len_err_ready: got %b want 1", s_ready); end
    // Idle byte: discarded, err stays sticky.
    send_byte(8'h3C, 0);
    repeat (2) @(negedge clk);
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL err_cpu_rst: got %b want 0", cpu_rst_n); end
    if (waddr_log.size() !== 0) begin errors++; $display("FAIL len_err_writes: got %0d want 0", waddr_log.size()); end
    fill_payload(4);
    send_frame(1, 2);
    @(negedge clk);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL recover_done: got %b want 1", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL recover_err: got %b want 0", err); end
    repeat (2) @(negedge clk);
    checks++;
    if (waddr_log.size() !== 4) begin errors++; $display("FAIL recover_count: got %0d want 4", waddr_log.size()); end
  endtask

  task automatic test_zero_len();
    clear_log();
    payload_q.delete();
    send_frame(0, 1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    repeat (2) @(negedge clk);
    checks += 2;
    if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_cpu_rst: got %b want 1", cpu_rst_n); end
    if (waddr_log.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", waddr_log.size()); end
  endtask

  task automatic test_max_len();
    int bad;
    clear_log();
    fill_payload(MEM_NBYTE);
    send_frame(MEM_NBYTE / 4, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL max_done: got %b want 1", done); end
    repeat (2) @(negedge clk);
    checks++;
    if (waddr_log.size() !== MEM_NBYTE) begin
      errors++; $display("FAIL max_count: got %0d want %0d", waddr_log.size(), MEM_NBYTE);
    end else begin
      bad = 0;
      for (int i = 0; i < MEM_NBYTE; i++)
        if (waddr_log[i] !== ADDR_W'(i) || wdata_log[i] !== payload_q[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL max_image: got %0d bad bytes want 0", bad); end
    end
  endtask

  task automatic test_random_valid();
    int words;
    for (int f = 0; f < 6; f++) begin
      words = int'($urandom_range(12, 1));
      fill_payload(4 * words);
      if (f % 2 == 0) payload_q[0] = 8'hA5;  // sync value inside payload is plain data
      clear_log();
      send_frame(words, 3);
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL rand%0d_done: got %b want 1", f, done); end
      repeat (2) @(negedge clk);
      checks++;
      if (waddr_log.size() !== 4 * words) begin
        errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, waddr_log.size(), 4 * words);
      end else begin
        for (int i = 0; i < 4 * words; i++) begin
          checks++;
          if (waddr_log[i] !== ADDR_W'(i) || wdata_log[i] !== payload_q[i]) begin
            errors++;
            $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h", f, i, waddr_log[i],
                     wdata_log[i], i, payload_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL mrst_s_ready: got %b want 1", s_ready); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL mrst_mem_we: got %b want 0", mem_we); end
    if (mem_waddr !== '0) begin errors++; $display("FAIL mrst_waddr: got %h want 0", mem_waddr); end
    if (mem_wdata !== 8'h00) begin errors++; $display("FAIL mrst_wdata: got %h want 0", mem_wdata); end
    if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL mrst_cpu_rst_n: got %b want 0", cpu_rst_n); end
    if (done !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b want 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL mrst_err: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    fill_payload(4);
    send_frame(1, 1);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL mrst_frame_done: got %b want 1", done); end
    repeat (2) @(negedge clk);
    checks++;
    if (waddr_log.size() !== 4) begin
      errors++; $display("FAIL mrst_count: got %0d want 4", waddr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (waddr_log[i] !== ADDR_W'(i) || wdata_log[i] !== payload_q[i]) begin
          errors++;
          $display("FAIL mrst_write%0d: got %h/%h want %h/%h", i, waddr_log[i], wdata_log[i],
                   i, payload_q[i]);
        end
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] chk_vals[2];
    chk_vals[0] = 8'h0F;
    chk_vals[1] = 8'h0E;
    for (int t = 0; t < 2; t++) begin
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h04, 0);
      send_byte(8'h08, 0);
      send_byte(chk_vals[t], 0);
      @(negedge clk);
      checks += 2;
      if (done !== (t == 0)) begin errors++; $display("FAIL chk%0d_done: got %b want %b", t, done, t == 0); end
      if (err !== (t == 1)) begin errors++; $display("FAIL chk%0d_err: got %b want %b", t, err, t == 1); end
      repeat (2) @(negedge clk);
      checks++;
      if (cpu_rst_n !== (t == 0)) begin
        errors++; $display("FAIL chk%0d_cpu_rst: got %b want %b", t, cpu_rst_n, t == 0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_garbage_prefix();
    test_len_err();
    test_zero_len();
    test_random_valid();
    test_mid_reset();
    test_max_len();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
